// File: rtl/serial_adder_seq_if.sv
// Handshake/operand bundle for serial_adder_seq.
// The sub line exists only when SERIAL_ADDER_SUB_MODE_EN is defined.
interface serial_adder_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_MODE_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_MODE_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_MODE_EN to add a subtract mode (sum = a - b, cout = no borrow).
module serial_adder_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic bit_sum;
  logic bit_carry;

  assign bit_sum   = a_reg[0] ^ b_reg[0] ^ c_reg;
  assign bit_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        // DONE behaves like IDLE except it only lasts one cycle, so a start
        // in the done cycle chains straight into the next operation.
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg <= bus.a;
`ifdef SERIAL_ADDER_SUB_MODE_EN
            b_reg <= bus.sub ? ~bus.b : bus.b;
            c_reg <= bus.sub | bus.cin;
`else
            b_reg <= bus.b;
            c_reg <= bus.cin;
`endif
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          sum_reg <= {bit_sum, sum_reg[WIDTH-1:1]};
          c_reg   <= bit_carry;
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            cout_reg  <= bit_carry;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule
